axi4lite_rr_master: RTL and testbench
=====================================

Name: axi4lite_rr_master

Overview:
- Two-requester AXI4-Lite master that shares the 8-bit, 4-register AXI4-Lite control slave between two on-chip clients.
- Each client issues simple single-beat read or write requests.
- The block grants requesters round-robin, sequences the AW/W/B or AR/R channel handshakes, and returns the data and response to the granted requester.
- It sits between the client logic and the slave's s_axi_* port, on the same clock.

Parameters:
- ADDR_W, 2, AXI address width (register index).
- DATA_W, 8, AXI data width.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_we  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  register address
- req0_wdata  in  DATA_W  write data
- req0_ready  out  1  request accepted this cycle
- resp0_valid  out  1  one-cycle completion pulse
- resp0_rdata  out  DATA_W  read data (0 for writes)
- resp0_resp  out  2  BRESP/RRESP copy
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata, resp1_resp: same as requester 0.
- m_axi_awaddr  out  ADDR_W
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_W
- m_axi_wstrb  out  1  (tied 1 while wvalid)
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_araddr  out  ADDR_W
- m_axi_arvalid  out  1
- m_axi_arready  in  1
- m_axi_rdata  in  DATA_W
- m_axi_rresp  in  2
- m_axi_rvalid  in  1
- m_axi_rready  out  1

Behaviour:
- Reset (async, s_axi_areset=1): state=IDLE, all outputs 0, last_grant=1 (so requester 0 wins first), captured we/addr/wdata/owner cleared.
- A reset mid-transaction abandons the transaction immediately. No response is issued.
- FSM states: IDLE, WRITE, B_WAIT, READ, R_WAIT, RESP.
- IDLE grant rules:
  - Only one reqN_valid high -> grant N.
  - Both high -> grant the one != last_grant.
- reqN_ready is combinational: (state==IDLE) && grant==N && reqN_valid. It is never high outside IDLE.
- Capture edge: on the accept edge, latch we/addr/wdata and owner, set last_grant=owner. Next state is WRITE if we, else READ.
- WRITE:
  - awvalid and wvalid both assert on the first WRITE cycle, carrying the latched addr/data.
  - Each drops on the edge of its own handshake (valid&&ready), independently.
  - Leave WRITE on the edge where the last outstanding handshake completes -> B_WAIT.
  - awvalid/wvalid never drop before their handshake.
- B_WAIT: bready=1. On bvalid, capture bresp, rdata_q=0 -> RESP.
- READ: arvalid=1 until arready edge -> R_WAIT.
- R_WAIT: rready=1. On rvalid, capture rdata/rresp -> RESP.
- RESP:
  - respN_valid=1 for exactly one cycle for the owner only, with resp/rdata valid that cycle.
  - The other requester's resp outputs stay 0.
  - Next state IDLE.
- Latency: accept edge -> awvalid/arvalid high next cycle. Response pulse is 1 cycle after the B/R handshake edge.
- One transaction in flight. A request arriving during a transaction waits (valid held by requester).
- bresp/rresp are forwarded unchanged. There is no local error generation.
- Requester inputs may change after acceptance without effect.
- A request with valid dropped before acceptance is not issued.
- Worst-case back-to-back: the next accept is in the IDLE cycle immediately following RESP.

Decomposition:
- Shared package: state encoding localparams (IDLE..RESP), AXI response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Natural sub-module: rr_arbiter2 (combinational grant from two valids + last_grant).
- The channel FSM stays in the top.

Test Plan:
- Single write: req0 write addr=2 wdata=0xA5 against the register-file slave -> req0_ready 1 cycle; AW and W handshakes complete; resp0_valid 1 cycle with resp=00; a following req0 read addr=2 returns rdata=0xA5.
- Contention: req0 and req1 both valid in IDLE after reset -> req0 granted first; with both held valid, grants alternate 0,1,0,1 over 4 transactions. No requester is starved.
- Independent AW/W: bench slave gives awready 3 cycles before wready -> awvalid drops on its handshake; wvalid held until its own handshake; only one write committed; exactly one B handshake.
- Backpressure: bench delays bvalid 5 cycles and rvalid 4 cycles -> bready/rready held; no response pulse until the handshake; then resp pulse next cycle for the correct owner.
- Error pass-through: bench returns rresp=2'b10, rdata=0x3C -> resp1_resp=10, resp1_rdata=0x3C; resp0_valid stays 0.
- Reset mid-write: assert s_axi_areset while in WRITE -> all outputs 0 asynchronously; after release, state IDLE; a new req1 read completes normally.

Source files
------------

// File: rtl/axi4lite_rr_master_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite master.
package axi4lite_rr_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StBWait,
    StRead,
    StRWait,
    StResp
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that did not win last time wins.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any_valid
);

  always_comb begin
    any_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else begin
      grant = valid1;
    end
  end

endmodule

// File: rtl/axi4lite_rr_master.sv
// Shares one AXI4-Lite slave between two single-beat requesters, one transaction in flight.
module axi4lite_rr_master
  import axi4lite_rr_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic [1:0]        resp0_resp,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic [1:0]        resp1_resp,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              grant, any_valid;

  rr_arbiter2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          we_d         = grant ? req1_we : req0_we;
          addr_d       = grant ? req1_addr : req0_addr;
          wdata_d      = grant ? req1_wdata : req0_wdata;
          owner_d      = grant;
          last_grant_d = grant;
          aw_pend_d    = we_d;
          w_pend_d     = we_d;
          state_d      = we_d ? StWrite : StRead;
        end
      end
      StWrite: begin
        // AW and W retire independently; leave once neither is outstanding.
        aw_pend_d = aw_pend_q & ~m_axi_awready;
        w_pend_d  = w_pend_q & ~m_axi_wready;
        if (!aw_pend_d && !w_pend_d) state_d = StBWait;
      end
      StBWait: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StRead: begin
        if (m_axi_arready) state_d = StRWait;
      end
      StRWait: begin
        if (m_axi_rvalid) begin
          resp_d  = m_axi_rresp;
          rdata_d = m_axi_rdata;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req0_ready = !s_axi_areset && (state_q == StIdle) && !grant && req0_valid;
  assign req1_ready = !s_axi_areset && (state_q == StIdle) && grant && req1_valid;

  assign m_axi_awvalid = (state_q == StWrite) && aw_pend_q;
  assign m_axi_awaddr  = m_axi_awvalid ? addr_q : '0;
  assign m_axi_wvalid  = (state_q == StWrite) && w_pend_q;
  assign m_axi_wdata   = m_axi_wvalid ? wdata_q : '0;
  assign m_axi_wstrb   = m_axi_wvalid;
  assign m_axi_bready  = (state_q == StBWait);
  assign m_axi_arvalid = (state_q == StRead);
  assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
  assign m_axi_rready  = (state_q == StRWait);

  assign resp0_valid = (state_q == StResp) && !owner_q;
  assign resp1_valid = (state_q == StResp) && owner_q;
  assign resp0_rdata = resp0_valid ? rdata_q : '0;
  assign resp1_rdata = resp1_valid ? rdata_q : '0;
  assign resp0_resp  = resp0_valid ? resp_q : '0;
  assign resp1_resp  = resp1_valid ? resp_q : '0;

endmodule

// File: tb/tb_axi4lite_rr_master.sv
// Scoreboard bench: directed requests, a latency-configurable register-file slave, response monitor.
module tb_axi4lite_rr_master;

  logic       s_axi_aclk = 1'b0;
  logic       s_axi_areset;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [1:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [7:0] resp0_rdata, resp1_rdata;
  logic [1:0] resp0_resp, resp1_resp;
  logic [1:0] m_axi_awaddr, m_axi_araddr, m_axi_bresp, m_axi_rresp;
  logic       m_axi_awvalid, m_axi_awready, m_axi_wstrb, m_axi_wvalid, m_axi_wready;
  logic       m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic       m_axi_rvalid, m_axi_rready;
  logic [7:0] m_axi_wdata, m_axi_rdata;

  axi4lite_rr_master #(.ADDR_W(2), .DATA_W(8)) dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_areset(s_axi_areset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata), .resp0_resp(resp0_resp),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata), .resp1_resp(resp1_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int cyc = 0;
  always @(posedge s_axi_aclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         owner;
    logic [7:0] rdata;
    logic [1:0] resp;
  } exp_t;
  exp_t sb[$];

  task automatic push(input int o, input logic [7:0] d, input logic [1:0] r);
    exp_t e;
    e.owner = o;
    e.rdata = d;
    e.resp  = r;
    sb.push_back(e);
  endtask

  // Register-file slave with per-channel ready/valid latencies.
  logic [7:0] regs [4];
  int aw_lat = 0, w_lat = 0, b_lat = 0, r_lat = 0;
  bit rerr = 0;
  int commits = 0, b_n = 0, hs_cyc = -10;
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w, b_pend, r_pend;
  int aw_cnt, w_cnt, b_cnt, r_cnt;
  logic [1:0] aw_addr_s, ar_addr_s;
  logic [7:0] wdata_s;

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
    m_axi_bresp = 2'b00;
    m_axi_rresp = 2'b00;
    m_axi_rdata = 8'h00;
    {have_aw, have_w, b_pend, r_pend} = '0;
    {aw_cnt, w_cnt, b_cnt, r_cnt} = '0;
    forever begin
      @(negedge s_axi_aclk);
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (b_hs || r_hs) hs_cyc = cyc;
      if (aw_hs) aw_addr_s = m_axi_awaddr;
      if (w_hs) wdata_s = m_axi_wdata;
      if (ar_hs) ar_addr_s = m_axi_araddr;
      @(posedge s_axi_aclk);
      #1;
      if (s_axi_areset) begin
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        {have_aw, have_w, b_pend, r_pend} = '0;
        {aw_cnt, w_cnt, b_cnt, r_cnt} = '0;
      end else begin
        if (aw_hs) begin
          m_axi_awready = 0; have_aw = 1; aw_cnt = 0;
        end else if (m_axi_awvalid && !m_axi_awready) begin
          if (aw_cnt >= aw_lat) m_axi_awready = 1; else aw_cnt++;
        end
        if (w_hs) begin
          m_axi_wready = 0; have_w = 1; w_cnt = 0;
        end else if (m_axi_wvalid && !m_axi_wready) begin
          if (w_cnt >= w_lat) m_axi_wready = 1; else w_cnt++;
        end
        if (b_hs) begin
          m_axi_bvalid = 0; b_pend = 0; b_n++;
        end
        if (have_aw && have_w && !b_pend) begin
          regs[aw_addr_s] = wdata_s; commits++;
          have_aw = 0; have_w = 0; b_pend = 1; b_cnt = 0;
        end
        if (b_pend && !m_axi_bvalid) begin
          if (b_cnt >= b_lat) begin m_axi_bvalid = 1; m_axi_bresp = 2'b00; end
          else b_cnt++;
        end
        if (r_hs) begin
          m_axi_rvalid = 0; r_pend = 0;
        end
        if (ar_hs) begin
          m_axi_arready = 0; r_pend = 1; r_cnt = 0;
        end else if (m_axi_arvalid && !m_axi_arready) begin
          m_axi_arready = 1;
        end
        if (r_pend && !m_axi_rvalid) begin
          if (r_cnt >= r_lat) begin
            m_axi_rvalid = 1;
            m_axi_rdata  = rerr ? 8'h3C : regs[ar_addr_s];
            m_axi_rresp  = rerr ? 2'b10 : 2'b00;
          end else r_cnt++;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  initial begin
    exp_t e;
    logic       own;
    forever begin
      @(negedge s_axi_aclk);
      if (!s_axi_areset && (resp0_valid || resp1_valid)) begin
        check("resp_onehot", {63'd0, resp0_valid & resp1_valid}, 64'd0);
        check("resp_expected", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          e   = sb.pop_front();
          own = resp1_valid;
          check("resp_owner", {63'd0, own}, e.owner);
          check("resp_rdata", own ? resp1_rdata : resp0_rdata, e.rdata);
          check("resp_code", own ? resp1_resp : resp0_resp, e.resp);
          check("resp_latency", cyc, hs_cyc + 1);
          check("resp_other_zero", own ? {resp0_rdata, resp0_resp} : {resp1_rdata, resp1_resp},
                64'd0);
        end
      end
    end
  end

  // Valids must hold until their handshake; wstrb follows wvalid.
  initial begin
    bit p_aw = 0, p_w = 0, p_ar = 0;
    forever begin
      @(negedge s_axi_aclk);
      if (s_axi_areset) begin
        p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw) check("awvalid_held", m_axi_awvalid, 1);
        if (p_w) check("wvalid_held", m_axi_wvalid, 1);
        if (p_ar) check("arvalid_held", m_axi_arvalid, 1);
        if (m_axi_wvalid) check("wstrb", m_axi_wstrb, 1);
        p_aw = m_axi_awvalid && !m_axi_awready;
        p_w  = m_axi_wvalid && !m_axi_wready;
        p_ar = m_axi_arvalid && !m_axi_arready;
      end
    end
  end

  task automatic issue(input int n, input logic we, input logic [1:0] addr, input logic [7:0] wd);
    bit got = 0;
    if (n == 0) begin
      req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1;
    end else begin
      req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge s_axi_aclk);
      got = (n == 0) ? req0_ready : req1_ready;
    end
    check($sformatf("accept_req%0d", n), {63'd0, got}, 64'd1);
    @(posedge s_axi_aclk);
    #1;
    // Scramble inputs after acceptance; the captured request must be unaffected.
    if (n == 0) begin
      req0_valid = 0; req0_we = ~we; req0_addr = ~addr; req0_wdata = ~wd;
    end else begin
      req1_valid = 0; req1_we = ~we; req1_addr = ~addr; req1_wdata = ~wd;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge s_axi_aclk);
    check("drain", sb.size(), 0);
    repeat (2) @(posedge s_axi_aclk);
    #1;
  endtask

  function automatic logic [63:0] all_outputs();
    return {22'd0, req0_ready, req1_ready, resp0_valid, resp0_rdata, resp0_resp, resp1_valid,
            resp1_rdata, resp1_resp, m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
            m_axi_wvalid, m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready};
  endfunction

  initial begin
    int order [4];
    int got, c0, b0;
    bit split;
    order = '{0, 1, 0, 1};
    s_axi_areset = 1;
    {req0_valid, req0_we, req1_valid, req1_we} = '0;
    {req0_addr, req1_addr} = '0;
    {req0_wdata, req1_wdata} = '0;
    repeat (3) @(posedge s_axi_aclk);
    #1;
    req0_valid = 1;
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    req0_valid = 0;
    @(negedge s_axi_aclk);
    s_axi_areset = 0;
    @(posedge s_axi_aclk);
    #1;
    check("idle_ready0_novalid", req0_ready, 0);

    // Contention: both held valid, grants must alternate starting with requester 0.
    push(0, 8'h00, 2'b00); push(1, 8'h11, 2'b00); push(0, 8'h00, 2'b00); push(1, 8'h11, 2'b00);
    req0_we = 1; req0_addr = 2'd0; req0_wdata = 8'h11; req0_valid = 1;
    req1_we = 0; req1_addr = 2'd0; req1_wdata = 8'h00; req1_valid = 1;
    got = 0;
    for (int i = 0; i < 300 && got < 4; i++) begin
      @(negedge s_axi_aclk);
      if (req0_ready || req1_ready) begin
        check("grant_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
        check($sformatf("grant_order_%0d", got), {63'd0, req1_ready}, order[got]);
        got++;
        @(posedge s_axi_aclk);
        #1;
        if (got == 4) begin req0_valid = 0; req1_valid = 0; end
      end
    end
    check("contention_accepts", got, 4);
    req0_valid = 0; req1_valid = 0;
    drain();

    // Single write then read-back.
    push(0, 8'h00, 2'b00);
    issue(0, 1, 2'd2, 8'hA5);
    drain();
    push(0, 8'hA5, 2'b00);
    issue(0, 0, 2'd2, 8'h00);
    drain();

    // AW accepted well before W.
    aw_lat = 0; w_lat = 3; c0 = commits; b0 = b_n; split = 0;
    push(0, 8'h00, 2'b00);
    issue(0, 1, 2'd1, 8'h5A);
    for (int i = 0; i < 15; i++) begin
      @(negedge s_axi_aclk);
      if (!m_axi_awvalid && m_axi_wvalid) split = 1;
    end
    drain();
    check("aw_w_split", {63'd0, split}, 64'd1);
    check("single_commit", commits - c0, 1);
    check("single_b", b_n - b0, 1);
    check("reg1_value", regs[1], 8'h5A);
    w_lat = 0;

    // B and R backpressure.
    b_lat = 5; r_lat = 4;
    push(1, 8'h00, 2'b00);
    issue(1, 1, 2'd3, 8'h77);
    drain();
    push(0, 8'h77, 2'b00);
    issue(0, 0, 2'd3, 8'h00);
    drain();
    b_lat = 0; r_lat = 0;

    // Slave error passes through unchanged.
    rerr = 1;
    push(1, 8'h3C, 2'b10);
    issue(1, 0, 2'd3, 8'h00);
    drain();
    rerr = 0;

    // Reset in the middle of a write abandons it without a response.
    aw_lat = 8; w_lat = 8; c0 = commits;
    issue(0, 1, 2'd2, 8'hFF);
    repeat (2) @(posedge s_axi_aclk);
    #2;
    s_axi_areset = 1;
    req1_we = 0; req1_addr = 2'd2; req1_valid = 1;
    #1;
    check("midwrite_reset_outputs", all_outputs(), 64'd0);
    repeat (2) @(posedge s_axi_aclk);
    @(negedge s_axi_aclk);
    req1_valid = 0;
    s_axi_areset = 0;
    aw_lat = 0; w_lat = 0;
    @(posedge s_axi_aclk);
    #1;
    push(1, 8'hA5, 2'b00);
    issue(1, 0, 2'd2, 8'h00);
    drain();
    check("aborted_write_not_committed", commits - c0, 0);
    check("sb_empty_at_end", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
